// File: rtl/rv_trace_pkg.sv
// rtl/rv_trace_pkg.sv - shared types and layout constants for the retirement trace buffer
package rv_trace_pkg;

    // Layout widths of one trace entry. The buffer's DATA_W/ADDR_W/TS_W
    // parameters default to these so the packed struct and ports line up.
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_ADDR_W = 9;
    localparam int TRACE_TS_W   = 16;
    localparam int TRACE_RD_W   = 5;
    localparam int DROP_W       = 16;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } mem_kind_e;

    // One captured cycle: register write-back and memory access side by side.
    // Fields belonging to an event that did not happen are held at zero.
    typedef struct packed {
        logic [TRACE_TS_W-1:0]   ts;
        logic                    reg_vld;
        logic [TRACE_RD_W-1:0]   rd;
        logic [TRACE_DATA_W-1:0] reg_data;
        mem_kind_e               kind;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] mem_data;
    } trace_entry_t;

    localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

    // A cycle that both reads and writes is ambiguous and is not recorded.
    function automatic mem_kind_e decode_mem_kind(input logic we, input logic re);
        if (we && !re) begin
            return WRITE;
        end
        if (re && !we) begin
            return READ;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/rv_trace_buffer_if.sv
// rtl/rv_trace_buffer_if.sv - head-of-buffer valid/ready stream carrying trace entries
interface rv_trace_buffer_if;
    import rv_trace_pkg::*;

    logic         out_valid;
    logic         out_ready;
    trace_entry_t out_entry;

    // The trace buffer drives the head entry, the consumer drives ready.
    modport master (
        output out_valid,
        output out_entry,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_entry,
        output out_ready
    );

endinterface

// File: rtl/rv_trace_fifo.sv
// rtl/rv_trace_fifo.sv - first-word-fall-through storage with a force-pop for overwrite mode
module rv_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    input  logic                   force_pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   valid_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;
    logic             do_push;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

    // Force-pop retires the head so a full buffer can take a new entry.
    assign do_pop  = (pop_i || force_pop_i) && valid_o;
    // A push into a full buffer only lands when a slot is freed the same edge.
    assign do_push = push_i && (!full_o || do_pop);

    // Head is read combinationally so the oldest entry is always presented.
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the buffer without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written on the same edge the entry is formed.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/rv_trace_buffer.sv
// rtl/rv_trace_buffer.sv - captures register/memory retirement events into a timestamped trace FIFO
module rv_trace_buffer
    import rv_trace_pkg::*;
#(
    parameter int DATA_W    = TRACE_DATA_W,
    parameter int ADDR_W    = TRACE_ADDR_W,
    parameter int TS_W      = TRACE_TS_W,
    parameter int DEPTH     = 16,
    parameter int FILTER_X0 = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   overwrite,
    input  logic                   RegWriteSignal,
    input  logic [4:0]             RegNum,
    input  logic [DATA_W-1:0]      RegData,
    input  logic                   WriteEnable,
    input  logic                   ReadEnable,
    input  logic [ADDR_W-1:0]      Address,
    input  logic [DATA_W-1:0]      WRData,
    input  logic [DATA_W-1:0]      RDData,
    rv_trace_buffer_if.master      out_if,
    output logic [$clog2(DEPTH):0] count,
    output logic [DROP_W-1:0]      drop_cnt
);

    logic                     reg_ev;
    mem_kind_e                kind;
    logic                     push_req;
    logic                     pop;
    logic                     full;
    logic                     valid;
    logic                     accept;
    logic                     force_pop;
    logic                     drop;
    trace_entry_t             entry;
    logic [TRACE_ENTRY_W-1:0] head_bits;
    logic [TS_W-1:0]          ts_q, ts_d;
    logic [DROP_W-1:0]        drop_q, drop_d;

    // Event qualification: x0 writes are architecturally invisible when filtered.
    assign reg_ev   = RegWriteSignal && !((FILTER_X0 != 0) && (RegNum == 5'd0));
    assign kind     = decode_mem_kind(WriteEnable, ReadEnable);
    assign push_req = en && (reg_ev || (kind != NONE));

    assign pop       = valid && out_if.out_ready;
    // Full with no same-cycle pop: the new entry is lost in stop mode,
    // or the oldest entry is sacrificed in overwrite mode. Either way one
    // event is gone, so both cases count as a drop.
    assign drop      = push_req && full && !pop;
    assign force_pop = drop && overwrite;
    assign accept    = push_req && (!full || pop || overwrite);

    // Entry packing with absent-event fields forced to zero.
    always_comb begin
        entry          = '0;
        entry.ts       = ts_q;
        entry.kind     = kind;
        if (reg_ev) begin
            entry.reg_vld  = 1'b1;
            entry.rd       = RegNum;
            entry.reg_data = RegData;
        end
        if (kind != NONE) begin
            entry.addr = Address;
        end
        case (kind)
            WRITE:   entry.mem_data = WRData;
            READ:    entry.mem_data = RDData;
            default: entry.mem_data = '0;
        endcase
    end

    // Free-running timestamp and saturating loss counter next-state.
    always_comb begin
        ts_d   = ts_q + 1'b1;
        drop_d = drop_q;
        if (drop && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // Timestamp and drop counter registers; reset overrides any event.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q   <= '0;
            drop_q <= '0;
        end else begin
            ts_q   <= ts_d;
            drop_q <= drop_d;
        end
    end

    rv_trace_fifo #(
        .WIDTH (TRACE_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept),
        .din_i       (entry),
        .pop_i       (pop),
        .force_pop_i (force_pop),
        .dout_o      (head_bits),
        .valid_o     (valid),
        .full_o      (full),
        .count_o     (count)
    );

    assign out_if.out_valid = valid;
    assign out_if.out_entry = head_bits;
    assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_rv_trace_buffer.sv
// tb/tb_rv_trace_buffer.sv - self-checking bench for rv_trace_buffer
module tb_rv_trace_buffer;
    import rv_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          overwrite;
    logic          RegWriteSignal;
    logic [4:0]    RegNum;
    logic [31:0]   RegData;
    logic          WriteEnable;
    logic          ReadEnable;
    logic [8:0]    Address;
    logic [31:0]   WRData;
    logic [31:0]   RDData;
    logic [CW-1:0] count;
    logic [15:0]   drop_cnt;

    rv_trace_buffer_if tif ();

    rv_trace_buffer #(
        .DATA_W    (32),
        .ADDR_W    (9),
        .TS_W      (16),
        .DEPTH     (DEPTH),
        .FILTER_X0 (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .overwrite      (overwrite),
        .RegWriteSignal (RegWriteSignal),
        .RegNum         (RegNum),
        .RegData        (RegData),
        .WriteEnable    (WriteEnable),
        .ReadEnable     (ReadEnable),
        .Address        (Address),
        .WRData         (WRData),
        .RDData         (RDData),
        .out_if         (tif),
        .count          (count),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of stored entries plus loss count and clock.
    trace_entry_t mq[$];
    int           m_drop;
    logic [15:0]  m_ts;

    typedef struct {
        logic         en, ow, rws;
        logic [4:0]   rn;
        logic [31:0]  rd;
        logic         we, re;
        logic [8:0]   a;
        logic [31:0]  wd, rdd;
        logic         rdy;
        int           e_cnt;
        logic         e_vld;
        int           e_drop;
        trace_entry_t e_head;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic trace_entry_t mke(input logic [15:0] ts, input logic rv, input logic [4:0] rd,
                                         input logic [31:0] rdat, input mem_kind_e k,
                                         input logic [8:0] a, input logic [31:0] md);
        trace_entry_t e;
        e.ts = ts; e.reg_vld = rv; e.rd = rd; e.reg_data = rdat;
        e.kind = k; e.addr = a; e.mem_data = md;
        return e;
    endfunction

    function automatic vec_t mkv(input logic e, input logic ow, input logic rws, input logic [4:0] rn,
                                 input logic [31:0] rd, input logic we, input logic re, input logic [8:0] a,
                                 input logic [31:0] wd, input logic [31:0] rdd, input logic rdy,
                                 input int ec, input logic ev, input int ed, input trace_entry_t eh);
        vec_t v;
        v.en = e; v.ow = ow; v.rws = rws; v.rn = rn; v.rd = rd; v.we = we; v.re = re;
        v.a = a; v.wd = wd; v.rdd = rdd; v.rdy = rdy;
        v.e_cnt = ec; v.e_vld = ev; v.e_drop = ed; v.e_head = eh;
        return v;
    endfunction

    task automatic apply(input logic e, input logic ow, input logic rws, input logic [4:0] rn,
                         input logic [31:0] rd, input logic we, input logic re, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] rdd, input logic rdy);
        en = e; overwrite = ow; RegWriteSignal = rws; RegNum = rn; RegData = rd;
        WriteEnable = we; ReadEnable = re; Address = a; WRData = wd; RDData = rdd;
        tif.out_ready = rdy;
    endtask

    // Advance one clock: update the model from the driven inputs, then compare.
    task automatic tick();
        trace_entry_t e;
        logic         reg_ev;
        mem_kind_e    k;
        if (rst) begin
            mq.delete();
            m_drop = 0;
            m_ts   = '0;
        end else begin
            reg_ev = RegWriteSignal && (RegNum != 5'd0);
            if (WriteEnable && !ReadEnable)      k = WRITE;
            else if (ReadEnable && !WriteEnable) k = READ;
            else                                 k = NONE;
            e = mke(m_ts, reg_ev, reg_ev ? RegNum : 5'd0, reg_ev ? RegData : 32'd0, k,
                    (k != NONE) ? Address : 9'd0,
                    (k == WRITE) ? WRData : ((k == READ) ? RDData : 32'd0));
            if (tif.out_ready && mq.size() > 0) void'(mq.pop_front());
            if (en && (reg_ev || k != NONE)) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(e);
                end else begin
                    if (overwrite) begin
                        void'(mq.pop_front());
                        mq.push_back(e);
                    end
                    if (m_drop < 65535) m_drop++;
                end
            end
            m_ts = m_ts + 16'd1;
        end
        @(posedge clk);
        #1;
        chk("count", count, mq.size());
        chk("out_valid", tif.out_valid, mq.size() != 0);
        chk("drop_cnt", drop_cnt, m_drop);
        if (mq.size() > 0) chk("head", tif.out_entry, mq[0]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic seq_full(input logic ow);
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            apply(1, ow, 1, 5'(k + 1), 32'(k), 0, 0, 0, 0, 0, 0);
            tick();
        end
        chk("full_count", count, 16);
        chk("full_drop", drop_cnt, 4);
        for (int j = 0; j < 16; j++) begin
            apply(1, ow, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            chk("drain_valid", tif.out_valid, 1);
            chk("drain_data", tif.out_entry.reg_data, ow ? 32'(j + 5) : 32'(j + 1));
            tick();
        end
        chk("drained_count", count, 0);
    endtask

    task automatic seq_pushpop_reset();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            apply(1, 0, 1, 5'(k), 32'(k), 0, 0, 0, 0, 0, 0);
            tick();
        end
        chk("pp_full", count, 16);
        apply(1, 0, 1, 5'd17, 32'd17, 0, 0, 0, 0, 0, 1);
        tick();
        chk("pp_count", count, 16);
        chk("pp_drop", drop_cnt, 0);
        chk("pp_head", tif.out_entry.reg_data, 32'd2);
        for (int j = 0; j < 3; j++) begin
            apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
        apply(1, 0, 1, 5'd1, 32'd99, 1, 0, 9'd4, 32'd5, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", tif.out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_drop", drop_cnt, 0);
        apply(1, 0, 1, 5'd3, 32'd3, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post_rst_ts", tif.out_entry.ts, 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_drop = 0;
        m_ts   = '0;

        // Row i is driven in the cycle whose timestamp is i after reset.
        vt[0]  = mkv(1, 0, 0, 5'd0, 32'h0,        0, 0, 9'd0,  32'h0,  32'h0,  1, 0, 0, 0, '0);
        vt[1]  = mkv(1, 0, 0, 5'd0, 32'h0,        0, 0, 9'd0,  32'h0,  32'h0,  1, 0, 0, 0, '0);
        vt[2]  = mkv(1, 0, 0, 5'd0, 32'h0,        0, 0, 9'd0,  32'h0,  32'h0,  1, 0, 0, 0, '0);
        vt[3]  = mkv(1, 0, 1, 5'd5, 32'h0000000A, 0, 0, 9'd0,  32'h0,  32'h0,  1, 1, 1, 0,
                     mke(16'd3, 1, 5'd5, 32'h0000000A, NONE, 9'd0, 32'h0));
        vt[4]  = mkv(1, 0, 0, 5'd0, 32'h0,        0, 0, 9'd0,  32'h0,  32'h0,  1, 0, 0, 0, '0);
        vt[5]  = mkv(1, 0, 1, 5'd7, 32'hFFFFFFFF, 1, 0, 9'd20, 32'h12, 32'h0,  0, 1, 1, 0,
                     mke(16'd5, 1, 5'd7, 32'hFFFFFFFF, WRITE, 9'd20, 32'h12));
        vt[6]  = mkv(1, 0, 0, 5'd0, 32'h0,        0, 0, 9'd0,  32'h0,  32'h0,  1, 0, 0, 0, '0);
        vt[7]  = mkv(1, 0, 1, 5'd0, 32'h55,       0, 0, 9'd0,  32'h0,  32'h0,  1, 0, 0, 0, '0);
        vt[8]  = mkv(1, 0, 0, 5'd0, 32'h0,        1, 1, 9'd3,  32'h44, 32'h66, 1, 0, 0, 0, '0);
        vt[9]  = mkv(1, 0, 0, 5'd3, 32'h5,        0, 1, 9'd33, 32'h99, 32'h77, 0, 1, 1, 0,
                     mke(16'd9, 0, 5'd0, 32'h0, READ, 9'd33, 32'h77));
        vt[10] = mkv(0, 0, 1, 5'd4, 32'h8,        1, 0, 9'd2,  32'h1,  32'h0,  0, 1, 1, 0,
                     mke(16'd9, 0, 5'd0, 32'h0, READ, 9'd33, 32'h77));
        vt[11] = mkv(1, 0, 0, 5'd0, 32'h0,        0, 0, 9'd0,  32'h0,  32'h0,  1, 0, 0, 0, '0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply(vt[i].en, vt[i].ow, vt[i].rws, vt[i].rn, vt[i].rd, vt[i].we, vt[i].re,
                  vt[i].a, vt[i].wd, vt[i].rdd, vt[i].rdy);
            tick();
            chk($sformatf("tbl%0d_count", i), count, vt[i].e_cnt);
            chk($sformatf("tbl%0d_valid", i), tif.out_valid, vt[i].e_vld);
            chk($sformatf("tbl%0d_drop", i), drop_cnt, vt[i].e_drop);
            if (vt[i].e_vld) chk($sformatf("tbl%0d_head", i), tif.out_entry, vt[i].e_head);
        end

        seq_full(1'b0);
        seq_full(1'b1);
        seq_pushpop_reset();

        // Randomised traffic: a fill-heavy phase followed by a drain-heavy phase.
        do_reset();
        begin
            logic ow = 1'b0;
            for (int i = 0; i < 1200; i++) begin
                if ($urandom_range(0, 39) == 0) ow = !ow;
                apply($urandom_range(0, 7) != 0, ow, 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                      $urandom, 1'($urandom), 1'($urandom), 9'($urandom), $urandom, $urandom,
                      (i < 600) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
                rst = ($urandom_range(0, 299) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
